// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing sequencer: op bit positions,
// sequencer states and the one-hot legality check on control words.
package alu_pkg;

    localparam int CTRL_W = 17;

    // Bit positions inside the one-hot ALU control word
    localparam int ADD  = 0;
    localparam int SUB  = 1;
    localparam int SLT  = 2;
    localparam int SLTU = 3;
    localparam int AND  = 4;
    localparam int OR   = 5;
    localparam int XOR  = 6;
    localparam int SLL  = 7;
    localparam int SRL  = 8;
    localparam int SRA  = 9;
    localparam int BEQ  = 10;
    localparam int BNE  = 11;
    localparam int BLT  = 12;
    localparam int BGE  = 13;
    localparam int BLTU = 14;
    localparam int BGEU = 15;
    localparam int LUI  = 16;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } ctrlState_e;

    function automatic logic is_onehot(input logic [CTRL_W-1:0] w);
        return (w != '0) && ((w & (w - CTRL_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side request/response bundle of the ALU sharing sequencer.
// Requesters use the master modport; the sequencer uses the slave modport.
interface alu_share_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 17
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_result;
    logic                      resp_zero;
    logic                      resp_err;

    modport master (
        output req_valid, req_ctrl, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position after
// the previous winner and wraps, so every requester eventually wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between several requesters: grant one request
// round-robin, drive the ALU for a single cycle, hold the result until taken.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 17
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_ctrl_if.slave    bus,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic [DATA_W-1:0]  alu_data1,
    output logic [DATA_W-1:0]  alu_data2,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ctrlState_e         state, stateNext;
    logic [IDX_W-1:0]   lastGrant, ownerIdx, grantIdx;
    logic [NUM_REQ-1:0] grant;
    logic               accept, illegal;
    logic [CTRL_W-1:0]  issueCtrl;
    logic [DATA_W-1:0]  issueA, issueB;
    logic [DATA_W-1:0]  respResult;
    logic               respZero, respErr;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) arbiter (
        .req        (bus.req_valid),
        .last_grant (lastGrant),
        .grant      (grant),
        .grant_idx  (grantIdx)
    );

    assign illegal = !is_onehot(issueCtrl);

    always_comb begin
        stateNext      = state;
        accept         = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        alu_ctrl       = '0;
        alu_data1      = '0;
        alu_data2      = '0;
        case (state)
            IDLE: begin
                // No grant while reset is asserted, even though state is IDLE
                if (!rst && (|bus.req_valid)) begin
                    accept        = 1'b1;
                    bus.req_ready = grant;
                    stateNext     = EXEC;
                end
            end
            EXEC: begin
                alu_ctrl  = illegal ? '0 : issueCtrl;
                alu_data1 = issueA;
                alu_data2 = issueB;
                stateNext = RESP;
            end
            RESP: begin
                bus.resp_valid[ownerIdx] = 1'b1;
                if (bus.resp_ready[ownerIdx]) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= IDX_W'(NUM_REQ - 1);
            ownerIdx  <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                lastGrant <= grantIdx;
                ownerIdx  <= grantIdx;
            end
        end
    end

    // Issue registers only matter while EXEC gates them onto the ALU
    always_ff @(posedge clk) begin
        if (accept) begin
            issueCtrl <= bus.req_ctrl[int'(grantIdx)*CTRL_W +: CTRL_W];
            issueA    <= bus.req_a[int'(grantIdx)*DATA_W +: DATA_W];
            issueB    <= bus.req_b[int'(grantIdx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            respResult <= '0;
            respZero   <= 1'b0;
            respErr    <= 1'b0;
        end else if (state == EXEC) begin
            respResult <= illegal ? '0 : alu_result;
            respZero   <= illegal ? 1'b0 : alu_zero;
            respErr    <= illegal;
        end
    end

    assign bus.resp_result = respResult;
    assign bus.resp_zero   = respZero;
    assign bus.resp_err    = respErr;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the alu_* ports
// and a scoreboard of expected responses.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int CW      = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    alu_share_ctrl_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CTRL_W(CW)) bus ();

    logic [CW-1:0]     aluCtrl;
    logic [DATA_W-1:0] aluData1, aluData2, aluResult;
    logic              aluZero;

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CTRL_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_ctrl   (aluCtrl),
        .alu_data1  (aluData1),
        .alu_data2  (aluData2),
        .alu_result (aluResult),
        .alu_zero   (aluZero)
    );

    // Behavioural stand-in for the ALU; branch ops report the condition on zero
    always_comb begin
        logic isBranch;
        aluResult = '0;
        aluZero   = 1'b0;
        isBranch  = 1'b0;
        case (1'b1)
            aluCtrl[ADD]:  aluResult = aluData1 + aluData2;
            aluCtrl[SUB]:  aluResult = aluData1 - aluData2;
            aluCtrl[SLT]:  aluResult = {31'd0, $signed(aluData1) < $signed(aluData2)};
            aluCtrl[SLTU]: aluResult = {31'd0, aluData1 < aluData2};
            aluCtrl[AND]:  aluResult = aluData1 & aluData2;
            aluCtrl[OR]:   aluResult = aluData1 | aluData2;
            aluCtrl[XOR]:  aluResult = aluData1 ^ aluData2;
            aluCtrl[SLL]:  aluResult = aluData1 << aluData2[4:0];
            aluCtrl[SRL]:  aluResult = aluData1 >> aluData2[4:0];
            aluCtrl[SRA]:  aluResult = $unsigned($signed(aluData1) >>> aluData2[4:0]);
            aluCtrl[BEQ]:  begin isBranch = 1'b1; aluZero = (aluData1 == aluData2); end
            aluCtrl[BNE]:  begin isBranch = 1'b1; aluZero = (aluData1 != aluData2); end
            aluCtrl[BLT]:  begin isBranch = 1'b1; aluZero = ($signed(aluData1) < $signed(aluData2)); end
            aluCtrl[BGE]:  begin isBranch = 1'b1; aluZero = ($signed(aluData1) >= $signed(aluData2)); end
            aluCtrl[BLTU]: begin isBranch = 1'b1; aluZero = (aluData1 < aluData2); end
            aluCtrl[BGEU]: begin isBranch = 1'b1; aluZero = (aluData1 >= aluData2); end
            aluCtrl[LUI]:  aluResult = aluData2;
            default:       aluResult = '0;
        endcase
        if (!isBranch) aluZero = (aluResult == '0);
    end

    typedef struct {
        int          owner;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   nCompared = 0;
    int   nFailed   = 0;
    int   t0, t1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [CW-1:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req_ctrl[i*CW +: CW]      = c;
        bus.req_a[i*DATA_W +: DATA_W] = a;
        bus.req_b[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic push(input int owner, input logic [31:0] r, input logic z, input logic e);
        exp_t x;
        x.owner = owner; x.result = r; x.zero = z; x.err = e;
        sb.push_back(x);
    endtask

    // Waits (bounded) for a response, then compares it with the oldest expectation
    task automatic checkResp(input string tag);
        int   n;
        exp_t x;
        n = 0;
        while (bus.resp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrived"}, {63'd0, bus.resp_valid != '0}, 64'd1);
        nCompared++;
        assert (sb.size() != 0) else begin
            nFailed++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() != 0 && bus.resp_valid != '0) begin
            x = sb.pop_front();
            chk({tag, "_owner"},  bus.resp_valid,  64'(1) << x.owner);
            chk({tag, "_result"}, bus.resp_result, x.result);
            chk({tag, "_zero"},   bus.resp_zero,   x.zero);
            chk({tag, "_err"},    bus.resp_err,    x.err);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_ctrl   = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '1;

        // Reset, with requests asserted: nothing may be accepted
        @(negedge clk);
        @(negedge clk);
        setReq(0, 17'h00001, 32'd1, 32'd1);
        bus.req_valid = 2'b11;
        #1;
        chk("rst_ready",  bus.req_ready,   0);
        chk("rst_rvalid", bus.resp_valid,  0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_zero",   bus.resp_zero,   0);
        chk("rst_err",    bus.resp_err,    0);
        chk("rst_alu",    {aluCtrl, aluData1, aluData2}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;

        // Concurrent pair after reset: req0 first, then req1
        @(negedge clk);
        setReq(0, 17'h00002, 32'd7, 32'd2);
        setReq(1, 17'h00200, 32'hC000_0000, 32'd2);
        bus.req_valid = 2'b11;
        #1;
        chk("pair_grant0", bus.req_ready, 2'b01);
        push(0, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("pair_exec_noready", bus.req_ready, 0);
        chk("pair_exec_ctrl", aluCtrl, 17'h00002);
        checkResp("pair_r0");
        @(negedge clk);
        #1;
        chk("pair_grant1", bus.req_ready, 2'b10);
        push(1, 32'hF000_0000, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        checkResp("pair_r1");
        @(negedge clk);
        chk("pair_idle_rvalid", bus.resp_valid, 0);

        // Single ADD with exact latency
        setReq(0, 17'h00001, 32'd1, 32'd3);
        bus.req_valid[0] = 1'b1;
        #1;
        chk("add_grant", bus.req_ready, 2'b01);
        push(0, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("add_exec_d1", aluData1, 32'd1);
        chk("add_exec_d2", aluData2, 32'd3);
        chk("add_exec_rvalid", bus.resp_valid, 0);
        @(negedge clk);
        chk("add_t2_rvalid", bus.resp_valid, 2'b01);
        checkResp("add");
        @(negedge clk);
        chk("add_idle_alu", {aluCtrl, aluData1, aluData2}, 0);

        // Second concurrent pair: req1 (BEQ) wins, response held with owner not ready
        setReq(1, 17'h00400, 32'd1, 32'd1);
        setReq(0, 17'h00003, 32'd5, 32'd5);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b01;
        #1;
        chk("hold_grant1", bus.req_ready, 2'b10);
        push(1, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_rvalid", bus.resp_valid,  2'b10);
            chk("hold_zero",   bus.resp_zero,   1'b1);
            chk("hold_result", bus.resp_result, 32'd0);
            chk("hold_ready",  bus.req_ready,   0);
            @(negedge clk);
        end
        bus.resp_ready = 2'b11;
        checkResp("hold_beq");

        // Pending req0 with an illegal two-bit control word
        @(negedge clk);
        #1;
        chk("illegal_grant0", bus.req_ready, 2'b01);
        push(0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("illegal_exec_ctrl", aluCtrl, 0);
        checkResp("illegal");

        // Reset during EXEC discards the operation
        @(negedge clk);
        setReq(0, 17'h00008, 32'd3, 32'd4);
        bus.req_valid[0] = 1'b1;
        #1;
        chk("sltu_grant", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("sltu_exec_ctrl", aluCtrl, 17'h00008);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_rvalid", bus.resp_valid, 0);
            chk("abort_alu", aluCtrl, 0);
            @(negedge clk);
        end
        bus.req_valid[0] = 1'b1;
        #1;
        chk("sltu2_grant", bus.req_ready, 2'b01);
        push(0, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        checkResp("sltu2");

        // Back-to-back BGEU then BLTU from req0
        @(negedge clk);
        setReq(0, 17'h08000, 32'd0, 32'd2);
        bus.req_valid[0] = 1'b1;
        #1;
        chk("btb_grant1", bus.req_ready, 2'b01);
        t0 = cycleCnt;
        push(0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        setReq(0, 17'h04000, 32'd0, 32'd2);
        @(negedge clk);
        chk("btb_resp_noready", bus.req_ready, 0);
        checkResp("bgeu");
        @(negedge clk);
        #1;
        chk("btb_grant2", bus.req_ready, 2'b01);
        t1 = cycleCnt;
        chk("btb_spacing", 64'(t1 - t0), 64'd3);
        push(0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        checkResp("bltu");

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
